// File: rtl/ins_cache_controller.sv
// ins_cache_controller
//   Direct-mapped, read-only instruction cache between the IF stage and a
//   128-bit-block instruction memory. Hits are served combinationally in the
//   same cycle; a miss stalls the pipeline, fetches the 16-byte block over the
//   mem_read/mem_busywait handshake, installs it and then serves the word.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   cpu_read            fetch request, held until cpu_busywait is low
//   cpu_address[31:0]   byte PC: [31:4] block, [3:2] word, [1:0] ignored
//   cpu_instruction     selected 32-bit word (valid on a hit)
//   cpu_busywait        pipeline stall
//   invalidate          one-cycle pulse clearing every valid bit
//   mem_read            block read request to instruction memory
//   mem_address[27:0]   block address of the outstanding miss
//   mem_readdata[127:0] returned block, byte k at bits [8k+7:8k]
//   mem_busywait        memory busy
//   miss_count          saturating count of misses since reset
module ins_cache_controller #(
  parameter int unsigned INDEX_BITS = 3,
  parameter int unsigned MISS_CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_read,
  input  logic [31:0]           cpu_address,
  output logic [31:0]           cpu_instruction,
  output logic                  cpu_busywait,
  input  logic                  invalidate,
  output logic                  mem_read,
  output logic [27:0]           mem_address,
  input  logic [127:0]          mem_readdata,
  input  logic                  mem_busywait,
  output logic [MISS_CNT_W-1:0] miss_count
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = 28 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    MEM_REQ,
    MEM_WAIT,
    UPDATE
  } state_t;

  state_t state, next_state;

  // Line storage: valid bits are reset, tag/data arrays are not.
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_array  [LINES];
  logic [127:0]      data_array [LINES];

  logic [27:0]       miss_addr;
  logic [MISS_CNT_W-1:0] miss_count_q;

  // Address decode for the live request
  logic [INDEX_BITS-1:0] cpu_index;
  logic [TAG_W-1:0]      cpu_tag;
  logic [1:0]            word_sel;
  logic                  hit;
  logic [127:0]          line_data;

  // Fill target comes from the latched miss address, not the live PC
  logic [INDEX_BITS-1:0] miss_index;
  logic [TAG_W-1:0]      miss_tag;

  logic [1:0] unused_byte_offset;

  assign cpu_index          = cpu_address[4+INDEX_BITS-1:4];
  assign cpu_tag            = cpu_address[31:4+INDEX_BITS];
  assign word_sel           = cpu_address[3:2];
  assign unused_byte_offset = cpu_address[1:0];

  assign miss_index = miss_addr[INDEX_BITS-1:0];
  assign miss_tag   = miss_addr[27:INDEX_BITS];

  assign line_data = data_array[cpu_index];
  assign hit       = valid[cpu_index] & (tag_array[cpu_index] == cpu_tag);

  // Little-endian word select, matching the memory byte order
  always_comb begin
    cpu_instruction = '0;
    case (word_sel)
      2'd0:    cpu_instruction = line_data[31:0];
      2'd1:    cpu_instruction = line_data[63:32];
      2'd2:    cpu_instruction = line_data[95:64];
      default: cpu_instruction = line_data[127:96];
    endcase
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (cpu_read && !hit) next_state = MEM_REQ;
      MEM_REQ:  if (mem_busywait)     next_state = MEM_WAIT;
      MEM_WAIT: if (!mem_busywait)    next_state = UPDATE;
      UPDATE:                         next_state = IDLE;
      default:                        next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_read     = 1'b0;
    cpu_busywait = 1'b1;
    case (state)
      IDLE:     cpu_busywait = cpu_read & ~hit;
      MEM_REQ:  mem_read     = 1'b1;
      MEM_WAIT: mem_read     = 1'b1;
      default:  mem_read     = 1'b0;
    endcase
  end

  assign mem_address = miss_addr;
  assign miss_count  = miss_count_q;

  // ------------------------------------------------------- control state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      miss_addr    <= '0;
      miss_count_q <= '0;
    end else if (state == IDLE && cpu_read && !hit) begin
      miss_addr <= cpu_address[31:4];
      if (miss_count_q != '1) begin
        miss_count_q <= miss_count_q + {{(MISS_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Invalidate is applied after the fill so a same-cycle pulse wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else begin
      if (state == UPDATE) begin
        valid[miss_index] <= 1'b1;
      end
      if (invalidate) begin
        valid <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (state == UPDATE) begin
      tag_array[miss_index]  <= miss_tag;
      data_array[miss_index] <= mem_readdata;
    end
  end

endmodule
